// File: rtl/spi_rx_pkg.sv
// Shared definitions for the DAC-side SPI receive path.
// DAC_W is also the word width default used by the matching SPI master.
package spi_rx_pkg;

  localparam int DAC_W = 12;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    LEAD,
    SHIFT,
    FULL
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer with a third flop for edge detection.
// level is the synchronized value; rise/fall are single-cycle strobes.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/spi_dac_rx.sv
// SPI slave receiver feeding the DAC core; all SPI lines are oversampled in clk.
// Emits a one-cycle done with the new word, or err for short/overrun frames.
module spi_dac_rx
  import spi_rx_pkg::*;
#(
  parameter int DATA_W     = DAC_W,
  parameter bit LSB_FIRST  = 1'b1,
  parameter int LEAD_EDGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              sclk,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam int LW = (LEAD_EDGES > 1) ? $clog2(LEAD_EDGES) : 1;
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_W - 1);
  localparam logic [LW-1:0] LAST_LEAD = LW'((LEAD_EDGES > 0) ? LEAD_EDGES - 1 : 0);
  localparam logic [CW-1:0] SETTLE    = CW'(2);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;
  logic unused_sclk;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst   (rst),
    .din   (cs),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst   (rst),
    .din   (sclk),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .din   (mosi),
    .level (mosi_lvl),
    .rise  (unused_mosi_rise),
    .fall  (unused_mosi_fall)
  );

  assign unused_sclk = sclk_lvl | sclk_rise;

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [CW-1:0]     bit_cnt, bit_cnt_n;
  logic [LW-1:0]     lead_cnt, lead_cnt_n;
  logic              ovr, ovr_n;
  logic              commit, commit_n;
  logic              fail, fail_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= WAIT_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      lead_cnt <= '0;
      ovr      <= 1'b0;
      commit   <= 1'b0;
      fail     <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      lead_cnt <= lead_cnt_n;
      ovr      <= ovr_n;
      commit   <= commit_n;
      fail     <= fail_n;
    end
  end

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    lead_cnt_n = lead_cnt;
    ovr_n      = ovr;
    commit_n   = 1'b0;
    fail_n     = 1'b0;

    case (state)
      // cs synchronizer resets high, so bit_cnt holds off the cs check until
      // the pin value has actually propagated to the synchronized level.
      WAIT_IDLE: begin
        if (bit_cnt != SETTLE) begin
          bit_cnt_n = bit_cnt + 1'b1;
        end else if (cs_lvl) begin
          bit_cnt_n = '0;
          state_n   = IDLE;
        end
      end

      IDLE: begin
        if (cs_fall) begin
          shreg_n    = '0;
          bit_cnt_n  = '0;
          lead_cnt_n = '0;
          ovr_n      = 1'b0;
          state_n    = (LEAD_EDGES == 0) ? SHIFT : LEAD;
        end
      end

      LEAD: begin
        if (cs_rise) begin
          fail_n  = 1'b1;
          state_n = IDLE;
        end else if (sclk_fall) begin
          if (lead_cnt == LAST_LEAD) state_n = SHIFT;
          else lead_cnt_n = lead_cnt + 1'b1;
        end
      end

      SHIFT: begin
        if (cs_rise) begin
          fail_n  = 1'b1;
          state_n = IDLE;
        end else if (sclk_fall) begin
          shreg_n   = LSB_FIRST ? {mosi_lvl, shreg[DATA_W-1:1]}
                                : {shreg[DATA_W-2:0], mosi_lvl};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) state_n = FULL;
        end
      end

      FULL: begin
        if (cs_rise) begin
          commit_n = ~ovr;
          fail_n   = ovr;
          state_n  = IDLE;
        end else if (sclk_fall) begin
          ovr_n = 1'b1;
        end
      end

      default: state_n = WAIT_IDLE;
    endcase
  end

  // shreg is still intact here: a new frame clears it on this same edge at the earliest.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= commit;
      err  <= fail;
      if (commit) dout <= shreg;
    end
  end

endmodule

// File: tb/tb_spi_dac_rx.sv
// Directed bench for spi_dac_rx: drives SPI frames and checks done/err/dout
// against a scoreboard of expected outcomes, plus an MSB-first instance.
`timescale 1ns/1ps
module tb_spi_dac_rx;
  import spi_rx_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic [11:0] dout, dout_msb;
  logic        done, err, done_msb, err_msb;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_err;
    logic [11:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;

  spi_dac_rx #(.DATA_W(12), .LSB_FIRST(1'b1), .LEAD_EDGES(1)) dut (
    .clk  (clk),
    .rst  (rst),
    .cs   (cs),
    .sclk (sclk),
    .mosi (mosi),
    .dout (dout),
    .done (done),
    .err  (err)
  );

  spi_dac_rx #(.DATA_W(12), .LSB_FIRST(1'b0), .LEAD_EDGES(1)) dut_msb (
    .clk  (clk),
    .rst  (rst),
    .cs   (cs),
    .sclk (sclk),
    .mosi (mosi),
    .dout (dout_msb),
    .done (done_msb),
    .err  (err_msb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic is_err, input logic [11:0] data);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every done/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && (done || err)) begin
      check("done_err_exclusive", {31'b0, done & err}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {30'b0, done, err}, 32'd0);
      end else begin
        cur = sb.pop_front();
        check("done", {31'b0, done}, {31'b0, ~cur.is_err});
        check("err", {31'b0, err}, {31'b0, cur.is_err});
        check("dout", {20'b0, dout}, {20'b0, cur.data});
      end
    end
  end

  // Master: cs low, lead sclk pulse, then nbits LSB-first bits, cs high.
  // rst_after >= 0 pulses reset after that many data bits.
  task automatic send_frame(input logic [11:0] word, input int nbits, input int rst_after);
    logic [11:0] w;
    w = word;
    @(negedge clk) cs = 1'b0;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_after) begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_reset_dout", {20'b0, dout}, 32'd0);
        check("mid_reset_done", {31'b0, done | err}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
      end
      sclk = 1'b1;
      mosi = (i < 12) ? w[i] : 1'b0;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    cs = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_dout", {20'b0, dout}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_err", {31'b0, err}, 32'd0);
    check("reset_dout_msb", {20'b0, dout_msb}, 32'd0);
    rst = 1'b1;
    repeat (8) @(negedge clk);

    // Good frame with latency check: done must appear on the 4th posedge after cs high.
    push_exp(1'b0, 12'hA5C);
    send_frame(12'hA5C, 12, -1);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      check("latency_done", {31'b0, done}, (k == 4) ? 32'd1 : 32'd0);
      check("latency_err", {31'b0, err}, 32'd0);
    end
    repeat (6) @(negedge clk);
    check("msb_first_a5c", {20'b0, dout_msb}, 32'h3A5);

    // Short frame: 7 data bits.
    push_exp(1'b1, 12'hA5C);
    send_frame(12'h0F0, 7, -1);
    repeat (10) @(negedge clk);
    check("short_keeps_dout", {20'b0, dout}, 32'hA5C);
    check("short_keeps_dout_msb", {20'b0, dout_msb}, 32'h3A5);

    // Overrun: 13 data bits.
    push_exp(1'b1, 12'hA5C);
    send_frame(12'h555, 13, -1);
    repeat (10) @(negedge clk);
    check("overrun_keeps_dout", {20'b0, dout}, 32'hA5C);

    // Back-to-back frames with a 3-clk cs-high gap.
    push_exp(1'b0, 12'h001);
    push_exp(1'b0, 12'hFFF);
    send_frame(12'h001, 12, -1);
    repeat (2) @(negedge clk);
    send_frame(12'hFFF, 12, -1);
    repeat (10) @(negedge clk);
    check("b2b_final_dout", {20'b0, dout}, 32'hFFF);

    // Reset mid-frame: the rest of this frame must produce nothing.
    send_frame(12'h3C3, 12, 6);
    repeat (10) @(negedge clk);
    check("post_reset_dout", {20'b0, dout}, 32'd0);

    push_exp(1'b0, 12'h123);
    send_frame(12'h123, 12, -1);
    repeat (10) @(negedge clk);

    // Serial pattern 1,0,...,0: LSB-first gives 0x001, MSB-first gives 0x800.
    push_exp(1'b0, 12'h001);
    send_frame(12'h001, 12, -1);
    repeat (10) @(negedge clk);
    check("msb_first_800", {20'b0, dout_msb}, 32'h800);
    check("lsb_first_001", {20'b0, dout}, 32'h001);

    repeat (10) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
